// File: rtl/sys_arr_feeder_if.sv
// Feeder-side bundle: start/k_len command, FIFO read port and PE-array edge.
// master drives commands, FIFO state and stall; slave is the feeder itself.
interface sys_arr_feeder_if #(
    parameter int BW = 2,
    parameter int KW = 8,
    parameter int WW = 8
);
    logic                   start;
    logic [KW-1:0]          k_len;
    logic                   fifo_empty;
    logic [BW-1:0][WW-1:0]  fifo_dat;
    logic                   fifo_pop;
    logic                   arr_stall;
    logic [BW-1:0][WW-1:0]  arr_dat;
    logic [BW-1:0]          arr_vld;
    logic                   busy;
    logic                   done;

    modport master (
        output start, k_len, fifo_empty, fifo_dat, arr_stall,
        input  fifo_pop, arr_dat, arr_vld, busy, done
    );

    modport slave (
        input  start, k_len, fifo_empty, fifo_dat, arr_stall,
        output fifo_pop, arr_dat, arr_vld, busy, done
    );
endinterface

// File: rtl/sys_arr_feeder.sv
// Drains k_len FIFO entries onto the systolic-array edge with diagonal skew
// (lane i lags lane 0 by i cycles), flushes the skew chain, then pulses done.
module sys_arr_feeder #(
    parameter int BW = 2,
    parameter int KW = 8,
    parameter int WW = 8
) (
    input  logic            clk,
    input  logic            nRST,
    sys_arr_feeder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    localparam int DW = $clog2(BW) + 1;
    localparam logic [DW-1:0] DLAST = DW'(BW - 2);

    state_t                 state, nxt;
    logic [KW-1:0]          count, k_len_q;
    logic [DW-1:0]          dcnt;
    logic                   adv, pop, last_pop;
    logic [BW-1:0][WW-1:0]  in_dat, out_dat;
    logic [BW-1:0]          out_vld;

    assign adv      = ~bus.arr_stall;
    assign pop      = (state == FEED) & ~bus.fifo_empty & adv & (count < k_len_q);
    assign last_pop = pop & ((count + KW'(1)) == k_len_q);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.start) nxt = (bus.k_len == '0) ? DONE : FEED;
            FEED:    if (last_pop) nxt = (BW == 1) ? DONE : DRAIN;
            DRAIN:   if (adv && (dcnt == DLAST)) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= nxt;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            count   <= '0;
            k_len_q <= '0;
            dcnt    <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                k_len_q <= bus.k_len;
                count   <= '0;
            end
            if (pop) count <= count + KW'(1);
            if (last_pop) dcnt <= '0;
            else if (state == DRAIN && adv) dcnt <= dcnt + DW'(1);
        end
    end

    assign in_dat = pop ? bus.fifo_dat : '0;

    // Lane i is an (i+1)-deep chain; all lanes share one advance enable so
    // bubbles and stalls never disturb the diagonal alignment.
    for (genvar i = 0; i < BW; i++) begin : g_lane
        logic [i:0][WW-1:0] sd;
        logic [i:0]         sv;

        always_ff @(posedge clk or negedge nRST) begin
            if (!nRST) begin
                sd <= '0;
                sv <= '0;
            end else if (adv) begin
                sd[0] <= in_dat[i];
                sv[0] <= pop;
                for (int unsigned j = 1; j <= i; j++) begin
                    sd[j] <= sd[j-1];
                    sv[j] <= sv[j-1];
                end
            end
        end

        assign out_dat[i] = sd[i];
        assign out_vld[i] = sv[i];
    end

    assign bus.arr_dat  = out_dat;
    assign bus.arr_vld  = out_vld;
    assign bus.fifo_pop = pop;
    assign bus.busy     = (state == FEED) | (state == DRAIN);
    assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_sys_arr_feeder.sv
// Scoreboard bench: a transaction-level model predicts pops, skewed lane
// outputs and done timing; a negedge monitor compares every cycle.
module tb_sys_arr_feeder;
    localparam int BW = 2;
    localparam int KW = 8;
    localparam int WW = 8;

    typedef logic [BW-1:0][WW-1:0] ent_t;
    typedef struct {
        int             a;
        int             lane;
        logic [WW-1:0]  d;
    } lexp_t;

    logic clk = 1'b0;
    logic nRST;
    always #5 clk = ~clk;

    sys_arr_feeder_if #(.BW(BW), .KW(KW), .WW(WW)) bus ();

    sys_arr_feeder #(.BW(BW), .KW(KW), .WW(WW)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    ent_t   fq[$];
    lexp_t  lq[$];

    bit             m_feed, m_wait, e_done;
    int             m_left, m_done_at, adv;
    logic [BW-1:0]  e_vld = '0;
    ent_t           e_dat = '0;
    int             n_chk = 0;
    int             n_fail = 0;

    bit m_adv, m_pop, m_idle, m_r;

    function automatic bit exp_pop();
        return (nRST === 1'b1) && m_feed && !bus.fifo_empty && !bus.arr_stall;
    endfunction

    function automatic ent_t mk(input int a, input int b);
        ent_t e;
        e[0] = a[WW-1:0];
        e[1] = b[WW-1:0];
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an entry popped on advance edge n shows on lane i
    // right after advance edge n+i; done follows the edge that exposes the
    // last entry on lane BW-1 (or the start edge when k_len is zero).
    always @(posedge clk) begin
        if (nRST !== 1'b1) begin
            m_feed = 0; m_wait = 0; e_done = 0;
            m_left = 0; m_done_at = 0; adv = 0;
            e_vld = '0; e_dat = '0;
            lq.delete();
        end else begin
            m_adv  = !bus.arr_stall;
            m_pop  = exp_pop();
            m_idle = !m_feed && !m_wait && !e_done;
            e_done = 0;
            if (m_adv) adv++;
            if (m_pop) begin
                for (int i = 0; i < BW; i++) lq.push_back('{adv + i, i, bus.fifo_dat[i]});
                m_left--;
                if (m_left == 0) begin
                    m_feed    = 0;
                    m_wait    = 1;
                    m_done_at = adv + BW - 1;
                end
            end
            if (m_wait && adv == m_done_at) begin
                m_wait = 0;
                e_done = 1;
            end
            if (m_idle && bus.start) begin
                if (bus.k_len == 0) e_done = 1;
                else begin
                    m_feed = 1;
                    m_left = int'(bus.k_len);
                end
            end
            if (m_adv) begin
                for (int i = 0; i < BW; i++) begin
                    e_vld[i] = 1'b0;
                    e_dat[i] = '0;
                    for (int q = 0; q < lq.size(); q++) begin
                        if (lq[q].a == adv && lq[q].lane == i) begin
                            e_vld[i] = 1'b1;
                            e_dat[i] = lq[q].d;
                            lq.delete(q);
                            break;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        m_r = (nRST === 1'b1);
        chk("fifo_pop", {31'b0, bus.fifo_pop}, {31'b0, exp_pop()});
        chk("busy",     {31'b0, bus.busy},     {31'b0, m_r && (m_feed || m_wait)});
        chk("done",     {31'b0, bus.done},     {31'b0, m_r && e_done});
        chk("arr_vld",  32'(bus.arr_vld),      m_r ? 32'(e_vld) : 32'd0);
        chk("arr_dat",  32'(bus.arr_dat),      m_r ? 32'(e_dat) : 32'd0);
    end

    task automatic drive_fifo();
        bus.fifo_empty = (fq.size() == 0);
        bus.fifo_dat   = (fq.size() > 0) ? fq[0] : '0;
    endtask

    task automatic step(input bit st, input logic [KW-1:0] k, input bit stl);
        bus.start     = st;
        bus.k_len     = k;
        bus.arr_stall = stl;
        drive_fifo();
        @(posedge clk);
        if (bus.fifo_pop === 1'b1 && fq.size() > 0) fq.delete(0);
        #1;
    endtask

    task automatic load3();
        fq.delete();
        fq.push_back(mk(1, 2));
        fq.push_back(mk(3, 4));
        fq.push_back(mk(5, 6));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        nRST = 1'b0;
        fq.delete();
        idle(3);
        nRST = 1'b1;
        idle(2);

        // basic three-entry feed
        load3();
        step(1'b1, 8'd3, 1'b0);
        idle(8);

        // stall in cycle 3
        load3();
        step(1'b1, 8'd3, 1'b0);
        idle(2);
        step(1'b0, '0, 1'b1);
        idle(8);

        // FIFO underrun: E1 arrives in cycle 4
        fq.delete();
        fq.push_back(mk(7, 8));
        step(1'b1, 8'd2, 1'b0);
        idle(3);
        fq.push_back(mk(9, 10));
        idle(8);

        // zero-length command
        step(1'b1, 8'd0, 1'b0);
        idle(4);

        // start while busy is ignored
        load3();
        step(1'b1, 8'd3, 1'b0);
        idle(1);
        step(1'b1, 8'd7, 1'b0);
        idle(8);

        // reset in cycle 3, then a fresh command
        load3();
        step(1'b1, 8'd3, 1'b0);
        idle(2);
        nRST = 1'b0;
        idle(2);
        nRST = 1'b1;
        idle(2);
        fq.push_back(mk(11, 12));
        fq.push_back(mk(13, 14));
        step(1'b1, 8'd3, 1'b0);
        idle(8);

        // randomized traffic
        fq.delete();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(99) < 45 && fq.size() < 12)
                fq.push_back(mk($urandom_range(255), $urandom_range(255)));
            if (c == 700) nRST = 1'b0;
            if (c == 703) nRST = 1'b1;
            step($urandom_range(99) < 12, KW'($urandom_range(9)), $urandom_range(99) < 25);
        end
        for (int c = 0; c < 40; c++) begin
            if (fq.size() < 2) fq.push_back(mk($urandom_range(255), $urandom_range(255)));
            step(1'b0, '0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sys_arr_feeder.md
Name: sys_arr_feeder

Overview:
- Drains BW-lane row entries from the input-buffer FIFO and drives one edge of the systolic array with diagonal skew: lane i lags lane 0 by i cycles.
- Sits directly downstream of the FIFO (consumes its dat_out, is_empty and pop) and directly upstream of the PE array edge.
- Feeds exactly k_len entries per start command, flushes the skew pipeline, then pulses done.

Parameters:
- BW, 2, number of lanes per entry; must match the FIFO BW.
- KW, 8, width of the k_len entry counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- nRST  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to feed k_len entries; honoured only in IDLE
- k_len  in  KW  number of FIFO entries to feed; latched on accepted start
- fifo_empty  in  1  FIFO is_empty
- fifo_dat  in  BW x word_t  FIFO dat_out; combinational, valid in the same cycle as the head entry
- fifo_pop  out  1  FIFO pop; combinational
- arr_stall  in  1  array back-pressure; freezes the feeder
- arr_dat  out  BW x word_t  skewed lane data, registered
- arr_vld  out  BW  per-lane valid, registered
- busy  out  1  high in FEED and DRAIN
- done  out  1  one-cycle pulse when the last entry leaves lane BW-1

Behaviour:
- Reset (async): state=IDLE, count=0, drain counter=0, all skew registers cleared, arr_dat=0, arr_vld=0, busy=0, done=0, fifo_pop=0.
- fifo_pop = (state==FEED) & ~fifo_empty & ~arr_stall & (count<k_len_q).
  - Never asserted while the FIFO is empty, so a pop is never issued on an empty FIFO.
  - fifo_pop is combinational, so it deasserts during reset.
- Advance occurs on any cycle with ~arr_stall, in every state.
  - Stage-0 input is fifo_dat with vld=1 when fifo_pop=1; otherwise data 0 with vld=0 (a bubble).
  - Lane i is a chain of i+1 registers; the last register drives arr_dat[i] and arr_vld[i].
  - An entry popped in cycle t appears on lane i in cycle t+1+i.
- Stall: arr_stall=1 holds all skew registers, count and drain counter; outputs are held and no pop occurs.
- Bubbles: an empty FIFO during FEED injects vld=0 entries, which advance coherently. Relative lane alignment is always preserved.
- FSM:
  - IDLE: on start, latch k_len into k_len_q and clear count. Go to FEED, or to DONE if k_len==0.
  - FEED: count increments on each pop.
    - On the cycle of the pop that makes count==k_len_q, go to DRAIN.
    - If BW==1, go to DONE instead.
  - DRAIN: stage-0 input is a bubble. Stay for BW-1 advance cycles; stalled cycles do not count. Then go to DONE.
  - DONE: done=1 for exactly one cycle regardless of arr_stall, then IDLE.
- start outside IDLE is ignored.
- k_len changes after acceptance have no effect.
- busy = (state==FEED)|(state==DRAIN).
- Widths:
  - count is KW bits and never exceeds k_len_q, so it cannot wrap.
  - Drain counter width is $clog2(BW)+1.
- Reset mid-operation aborts immediately:
  - no done pulse;
  - skew contents are discarded;
  - FIFO contents are untouched (the FIFO has its own reset).

Test Plan:
- BW=2, FIFO preloaded with E0=(1,2), E1=(3,4), E2=(5,6) (lane0,lane1); start with k_len=3 in cycle 0, no stall.
  - Response: fifo_pop in cycles 1-3; arr_dat[0]=1,3,5 with vld in cycles 2-4; arr_dat[1]=2,4,6 with vld in cycles 3-5; DRAIN in cycle 4; done=1 in cycle 5 only; busy cycles 1-4.
- Same setup with arr_stall=1 in cycle 3.
  - Response: no pop in cycle 3 and all outputs held equal to their cycle-2 values.
  - Every later event shifts by one cycle; done in cycle 6.
- FIFO holds only E0 at start with k_len=2; E1 is pushed so that it is visible in cycle 4.
  - Response: pops in cycles 1 and 4, with vld=0 bubbles between them on both lanes.
  - Lane1 vld pattern is lane0's pattern delayed by one cycle; done in cycle 6.
- start with k_len=0.
  - Response: no fifo_pop, arr_vld stays 0, done=1 in cycle 1, busy never asserts.
- start pulsed again in cycle 2 of the first scenario with k_len=7.
  - Response: ignored; exactly 3 pops and one done pulse.
- nRST asserted low in cycle 3 of the first scenario.
  - Response: within the same cycle arr_vld=0, arr_dat=0, fifo_pop=0 and busy=0.
  - After release the block is in IDLE, there is no done pulse, and a new start feeds correctly.
